// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite slave over a DEPTH x 32-bit memory with WAIT_STATES wait cycles per OKAY transfer and a 2-cycle ERROR response; inputs hclk/hresetn/hsel/haddr/hwrite/hsize/hburst/hprot/htrans/hready/hwdata, outputs hreadyout/hresp/hrdata
module ahb_slave_mem #(
  parameter int DEPTH = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [1:0]  htrans,
  input  logic        hready,
  input  logic [31:0] hwdata,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_READY, S_WAIT, S_ERR1, S_ERR2} state_t;
  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          act_q, act_d;
  logic          write_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    lane_q, size_q;
  logic [31:0]   mem_q [DEPTH];
  logic          accept, err, commit;
  logic [3:0]    be;
  logic          unused;
  assign unused = ^{hburst, hprot, htrans[0]};
  assign accept = hsel & hready & htrans[1] & hreadyout;
  assign err = (haddr >= 32'(DEPTH * 4)) || (hsize > 3'd2) || (hsize == 3'd1 && haddr[0]) ||
               (hsize == 3'd2 && haddr[1:0] != 2'd0);
  assign hreadyout = state_q == S_READY || state_q == S_ERR2;
  assign hresp = state_q == S_ERR1 || state_q == S_ERR2;
  assign hrdata = act_q && !write_q ? mem_q[idx_q] : '0;
  assign commit = act_q && write_q && state_q == S_READY;
  assign be = size_q == 2'd0 ? 4'b0001 << lane_q : size_q == 2'd1 ? 4'b0011 << lane_q : 4'b1111;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    act_d = act_q;
    case (state_q)
      S_READY, S_ERR2: begin
        state_d = S_READY;
        act_d = 1'b0;
        if (accept && err) state_d = S_ERR1;
        else if (accept) begin
          act_d = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d = 3'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        state_d = cnt_q == 3'd1 ? S_READY : S_WAIT;
      end
      S_ERR1: state_d = S_ERR2;
      default: state_d = S_READY;
    endcase
  end
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_READY;
      cnt_q <= '0;
      act_q <= 1'b0;
      write_q <= 1'b0;
      idx_q <= '0;
      lane_q <= '0;
      size_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
      if (accept) begin
        write_q <= hwrite;
        idx_q <= haddr[AW+1:2];
        lane_q <= haddr[1:0];
        size_q <= hsize[1:0];
      end
    end
  end
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) mem_q <= '{default: '0};
    else if (commit)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
  end
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: two slaves (0 and 1 wait states) driven by a pipelined bus model and checked against a transaction-level reference
module tb_ahb_slave_mem;
  localparam int DEPTH = 16;
  localparam int AW = $clog2(DEPTH);
  localparam int WS0 = 0;
  localparam int WS1 = 1;
  localparam logic [1:0] IDLE = 2'd0, NS = 2'd2;
  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel [2], hwrite [2], hr_low [2], hreadyout [2], hresp [2], hready [2];
  logic [31:0] haddr [2], hwdata [2], hrdata [2];
  logic [2:0]  hsize [2], hburst [2];
  logic [3:0]  hprot [2];
  logic [1:0]  htrans [2];
  logic [31:0] mem_m [2][DEPTH];
  logic        pv [2], perr [2], pw [2];
  logic [31:0] pa [2];
  logic [2:0]  psz [2];
  int          errs = 0, checks = 0;
  always #5 hclk = ~hclk;
  assign hready[0] = hreadyout[0] & ~hr_low[0];
  assign hready[1] = hreadyout[1] & ~hr_low[1];
  ahb_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(WS0)) u0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel[0]), .haddr(haddr[0]), .hwrite(hwrite[0]),
    .hsize(hsize[0]), .hburst(hburst[0]), .hprot(hprot[0]), .htrans(htrans[0]), .hready(hready[0]),
    .hwdata(hwdata[0]), .hreadyout(hreadyout[0]), .hresp(hresp[0]), .hrdata(hrdata[0])
  );
  ahb_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(WS1)) u1 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel[1]), .haddr(haddr[1]), .hwrite(hwrite[1]),
    .hsize(hsize[1]), .hburst(hburst[1]), .hprot(hprot[1]), .htrans(htrans[1]), .hready(hready[1]),
    .hwdata(hwdata[1]), .hreadyout(hreadyout[1]), .hresp(hresp[1]), .hrdata(hrdata[1])
  );
  function automatic int ws(input int d);
    return d == 0 ? WS0 : WS1;
  endfunction
  function automatic logic is_err(input logic [31:0] a, input logic [2:0] s);
    return a >= 32'(DEPTH * 4) || s > 3'd2 || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'd0);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      pv[d] = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_m[d][i] = '0;
    end
  endtask
  task automatic commit(input int d, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int lane, n;
    lane = int'(a[1:0]);
    n = 1 << sz;
    for (int b = 0; b < 4; b++)
      if (b >= lane && b < lane + n) mem_m[d][a[AW+1:2]][8*b +: 8] = wd[8*b +: 8];
  endtask
  // One bus cycle group: finishes the pending data phase (driving wd) while presenting a new address phase.
  task automatic step(input int d, input logic sel, input logic [1:0] tr, input logic [31:0] a,
                      input logic wr, input logic [2:0] sz, input logic [31:0] wd, input logic low);
    int n;
    logic [31:0] rd;
    n = !pv[d] ? 1 : perr[d] ? 2 : ws(d) + 1;
    for (int c = 0; c < n; c++) begin
      @(negedge hclk);
      hsel[d] = sel;
      htrans[d] = tr;
      haddr[d] = a;
      hwrite[d] = wr;
      hsize[d] = sz;
      hwdata[d] = wd;
      hr_low[d] = low;
      hburst[d] = 3'($urandom);
      hprot[d] = 4'($urandom);
      #1;
      rd = pv[d] && !perr[d] && !pw[d] ? mem_m[d][pa[d][AW+1:2]] : 32'd0;
      chk($sformatf("d%0d hreadyout c%0d", d, c), 32'(hreadyout[d]), 32'(c == n - 1));
      chk($sformatf("d%0d hresp c%0d", d, c), 32'(hresp[d]), 32'(pv[d] && perr[d]));
      chk($sformatf("d%0d hrdata c%0d", d, c), hrdata[d], rd);
    end
    if (pv[d] && !perr[d] && pw[d]) commit(d, pa[d], psz[d], wd);
    pv[d] = sel && tr[1] && !low;
    perr[d] = is_err(a, sz);
    pw[d] = wr;
    pa[d] = a;
    psz[d] = sz;
  endtask
  task automatic park(input int d);
    step(d, 1'b0, IDLE, 32'd0, 1'b0, 3'd0, 32'($urandom), 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] a;
    logic [2:0] sz;
    for (int d = 0; d < 2; d++) begin
      hsel[d] = 0; htrans[d] = IDLE; haddr[d] = 0; hwrite[d] = 0; hsize[d] = 0;
      hwdata[d] = 0; hr_low[d] = 0; hburst[d] = 0; hprot[d] = 0;
    end
    model_reset();
    repeat (2) @(posedge hclk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d reset hreadyout", d), 32'(hreadyout[d]), 32'd1);
      chk($sformatf("d%0d reset hresp", d), 32'(hresp[d]), 32'd0);
      chk($sformatf("d%0d reset hrdata", d), hrdata[d], 32'd0);
    end
    @(negedge hclk);
    hresetn = 1'b1;
    step(1, 1, NS, 32'h8, 1, 3'd2, 32'd0, 0);
    step(1, 1, NS, 32'h8, 0, 3'd2, 32'hDEADBEEF, 0);
    step(1, 1, NS, 32'h9, 1, 3'd0, 32'd0, 0);
    step(1, 1, NS, 32'hA, 1, 3'd1, 32'h0000AA00, 0);
    step(1, 1, NS, 32'h8, 0, 3'd2, 32'h12340000, 0);
    step(1, 1, NS, 32'h40, 0, 3'd2, 32'd0, 0);
    step(1, 1, NS, 32'h3, 1, 3'd1, 32'd0, 0);
    step(1, 1, NS, 32'h8, 0, 3'd2, 32'hFFFFFFFF, 0);
    step(1, 1, NS, 32'h8, 1, 3'd2, 32'd0, 1);
    step(1, 1, NS, 32'h8, 0, 3'd2, 32'h55555555, 0);
    park(1);
    step(0, 1, NS, 32'h0, 1, 3'd2, 32'd0, 0);
    step(0, 1, NS, 32'h0, 0, 3'd2, 32'h11, 0);
    step(0, 1, IDLE, 32'h0, 0, 3'd2, 32'd0, 0);
    step(0, 1, IDLE, 32'h4, 1, 3'd2, 32'd0, 0);
    step(0, 1, NS, 32'h0, 0, 3'd2, 32'd0, 0);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 250; i++) begin
        a = 32'($urandom_range(0, DEPTH * 4 + 7));
        sz = $urandom_range(0, 9) < 9 ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
        if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << (sz > 3'd2 ? 3'd0 : sz)) - 32'd1);
        step(d, $urandom_range(0, 5) != 0, 2'($urandom_range(0, 3)), a, 1'($urandom),
             sz, $urandom, $urandom_range(0, 9) == 0);
      end
      park(d);
    end
    step(1, 1, NS, 32'h4, 1, 3'd2, 32'd0, 0);
    @(negedge hclk);
    hsel[1] = 0; htrans[1] = IDLE; hwdata[1] = 32'hCAFEF00D;
    #1;
    chk("rst-mid wait hreadyout", 32'(hreadyout[1]), 32'd0);
    #1;
    hresetn = 1'b0;
    #1;
    chk("rst-mid hreadyout", 32'(hreadyout[1]), 32'd1);
    chk("rst-mid hresp", 32'(hresp[1]), 32'd0);
    chk("rst-mid hrdata", hrdata[1], 32'd0);
    model_reset();
    #1;
    hresetn = 1'b1;
    step(1, 1, NS, 32'h4, 0, 3'd2, 32'd0, 0);
    step(1, 1, NS, 32'h8, 0, 3'd2, 32'd0, 0);
    park(1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
